// File: rtl/switch_sequencer.sv
// Command sequencer for a crosspoint switch array: queues host commands in an
// 8-deep FIFO and replays them one at a time through a cs / rdy handshake.
module switch_sequencer (
   input  logic        clk,
   input  logic        rst,
   input  logic        cmd_valid,
   input  logic [12:0] cmd_word,
   output logic        cmd_ready,
   input  logic        go,
   input  logic        abort,
   output logic        sw_cs,
   output logic [3:0]  sw_op,
   output logic [7:0]  sw_addr,
   output logic [15:0] sw_data,
   input  logic        sw_rdy,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic [3:0]  level
);

   // state   | meaning
   // IDLE    | waiting for go; FIFO may be filled
   // ISSUE   | one-cycle sw_cs strobe, head entry popped
   // WAIT_LO | waiting for the switch to drop sw_rdy
   // WAIT_HI | waiting for the switch to raise sw_rdy again
   // ERROR   | handshake timed out; parked until abort
   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      ISSUE   = 3'd1,
      WAIT_LO = 3'd2,
      WAIT_HI = 3'd3,
      ERROR   = 3'd4
   } state_t;

   localparam logic [3:0] FIFO_FULL = 4'd8;
   localparam logic [6:0] TMO_LIMIT = 7'd100;
   localparam logic [3:0] OP_RESET  = 4'b0001;
   localparam logic [3:0] OP_WRITE  = 4'b0010;

   state_t      state_q, state_d;
   logic [12:0] mem_q [8];
   logic [12:0] mem_d [8];
   logic [2:0]  wr_ptr_q, wr_ptr_d;
   logic [2:0]  rd_ptr_q, rd_ptr_d;
   logic [3:0]  level_q, level_d;
   logic [6:0]  tmo_q, tmo_d;
   logic        err_q, err_d;
   logic        done_q, done_d;
   logic [7:0]  sw_addr_q, sw_addr_d;
   logic [15:0] sw_data_q, sw_data_d;

   logic        push;
   logic        pop;
   logic        flush;
   logic        issue;
   logic [12:0] head;
   logic [3:0]  head_op;
   logic [7:0]  head_addr;
   logic [15:0] head_data;

   // ---------------------------------------------------------------- FSM
   always_comb begin
      state_d = state_q;
      tmo_d   = tmo_q;
      err_d   = err_q;
      done_d  = 1'b0;
      pop     = 1'b0;
      flush   = 1'b0;
      if (abort) begin
         state_d = IDLE;
         flush   = 1'b1;
         err_d   = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (go) begin
                  if (level_q != 4'd0) state_d = ISSUE;
                  else                 done_d  = 1'b1;
               end
            end
            ISSUE: begin
               pop     = 1'b1;
               state_d = WAIT_LO;
               tmo_d   = 7'd0;
            end
            WAIT_LO: begin
               if (!sw_rdy) begin
                  state_d = WAIT_HI;
                  tmo_d   = 7'd0;
               end else if (tmo_q == TMO_LIMIT) begin
                  state_d = ERROR;
                  err_d   = 1'b1;
                  flush   = 1'b1;
               end else begin
                  tmo_d = tmo_q + 7'd1;
               end
            end
            WAIT_HI: begin
               if (sw_rdy) begin
                  if (level_q != 4'd0) begin
                     state_d = ISSUE;
                  end else begin
                     state_d = IDLE;
                     done_d  = 1'b1;
                  end
               end else if (tmo_q == TMO_LIMIT) begin
                  state_d = ERROR;
                  err_d   = 1'b1;
                  flush   = 1'b1;
               end else begin
                  tmo_d = tmo_q + 7'd1;
               end
            end
            ERROR: begin
               state_d = ERROR;
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   // --------------------------------------------------------------- FIFO
   // A flush (abort or timeout) wins over any push offered in the same cycle.
   assign push = cmd_valid && cmd_ready && (state_q != ERROR) && !flush;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (flush) begin
         wr_ptr_d = 3'd0;
         rd_ptr_d = 3'd0;
         level_d  = 4'd0;
      end else begin
         if (push) begin
            mem_d[wr_ptr_q] = cmd_word;
            wr_ptr_d        = wr_ptr_q + 3'd1;
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + 3'd1;
         end
         case ({push, pop})
            2'b10:   level_d = level_q + 4'd1;
            2'b01:   level_d = level_q - 4'd1;
            default: level_d = level_q;
         endcase
      end
   end

   // ------------------------------------------------------ switch port
   assign issue     = (state_q == ISSUE);
   assign head      = mem_q[rd_ptr_q];
   assign head_op   = head[12] ? OP_RESET : OP_WRITE;
   assign head_addr = {4'b0000, head[11:8]};
   assign head_data = {7'b0000000, head[7], 1'b0, head[6:4], head[3:0]};

   // Address/data are shown live during the strobe and held afterwards.
   always_comb begin
      sw_addr_d = sw_addr_q;
      sw_data_d = sw_data_q;
      if (issue) begin
         sw_addr_d = head_addr;
         sw_data_d = head_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         for (int i = 0; i < 8; i++) mem_q[i] <= 13'd0;
         wr_ptr_q  <= 3'd0;
         rd_ptr_q  <= 3'd0;
         level_q   <= 4'd0;
         tmo_q     <= 7'd0;
         err_q     <= 1'b0;
         done_q    <= 1'b0;
         sw_addr_q <= 8'd0;
         sw_data_q <= 16'd0;
      end else begin
         state_q   <= state_d;
         mem_q     <= mem_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         level_q   <= level_d;
         tmo_q     <= tmo_d;
         err_q     <= err_d;
         done_q    <= done_d;
         sw_addr_q <= sw_addr_d;
         sw_data_q <= sw_data_d;
      end
   end

   assign cmd_ready = (level_q != FIFO_FULL);
   assign sw_cs     = issue;
   assign sw_op     = issue ? head_op : 4'd0;
   assign sw_addr   = sw_addr_d;
   assign sw_data   = sw_data_d;
   assign busy      = (state_q != IDLE);
   assign done      = done_q;
   assign err       = err_q;
   assign level     = level_q;

endmodule

// File: tb/tb_switch_sequencer.sv
// Directed bench for switch_sequencer: table of single commands plus
// hand-written sequences for fill/drain, timeout, abort and mid-run reset.
module tb_switch_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid;
   logic [12:0] cmd_word;
   logic        cmd_ready;
   logic        go;
   logic        abort;
   logic        sw_cs;
   logic [3:0]  sw_op;
   logic [7:0]  sw_addr;
   logic [15:0] sw_data;
   logic        sw_rdy;
   logic        busy;
   logic        done;
   logic        err;
   logic [3:0]  level;

   int checks   = 0;
   int failures = 0;
   int cs_cnt   = 0;

   switch_sequencer dut (
      .clk       (clk),
      .rst       (rst),
      .cmd_valid (cmd_valid),
      .cmd_word  (cmd_word),
      .cmd_ready (cmd_ready),
      .go        (go),
      .abort     (abort),
      .sw_cs     (sw_cs),
      .sw_op     (sw_op),
      .sw_addr   (sw_addr),
      .sw_data   (sw_data),
      .sw_rdy    (sw_rdy),
      .busy      (busy),
      .done      (done),
      .err       (err),
      .level     (level)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (sw_cs === 1'b1) cs_cnt++;

   typedef struct {
      logic [12:0] word;
      logic [3:0]  op;
      logic [7:0]  addr;
      logic [15:0] data;
      int          lo_d;
      int          hi_d;
   } vec_t;

   vec_t vecs [5];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_cmd(input logic [12:0] w);
      cmd_valid = 1'b1;
      cmd_word  = w;
      step();
      cmd_valid = 1'b0;
   endtask

   task automatic pulse_go();
      go = 1'b1;
      step();
      go = 1'b0;
   endtask

   task automatic wait_cs(input int max, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < max; i++) begin
         if (sw_cs === 1'b1) begin
            ok = 1'b1;
            break;
         end
         step();
      end
   endtask

   // Starts in the strobe cycle; rdy falls lo_d cycles after cs and rises hi_d later.
   task automatic finish_cmd(input int lo_d, input int hi_d);
      step();
      repeat (lo_d - 1) step();
      sw_rdy = 1'b0;
      repeat (hi_d) step();
      sw_rdy = 1'b1;
   endtask

   task automatic count_done(input int n, output int cnt);
      cnt = 0;
      repeat (n) begin
         step();
         if (done === 1'b1) cnt++;
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_cs"},    sw_cs,     1'b0);
      chk({tag, "_op"},    sw_op,     4'd0);
      chk({tag, "_addr"},  sw_addr,   8'd0);
      chk({tag, "_data"},  sw_data,   16'd0);
      chk({tag, "_busy"},  busy,      1'b0);
      chk({tag, "_done"},  done,      1'b0);
      chk({tag, "_err"},   err,       1'b0);
      chk({tag, "_level"}, level,     4'd0);
      chk({tag, "_ready"}, cmd_ready, 1'b1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit          ok;
      int          cnt;
      int          base;
      int          cyc;
      logic [12:0] w;
      logic [15:0] exp_data;

      vecs[0] = '{13'h03A5, 4'd2, 8'h03, 16'h0125, 2, 10};
      vecs[1] = '{13'h1500, 4'd1, 8'h05, 16'h0000, 1, 1};
      vecs[2] = '{13'h0F7F, 4'd2, 8'h0F, 16'h007F, 3, 5};
      vecs[3] = '{13'h10DA, 4'd1, 8'h00, 16'h015A, 2, 2};
      vecs[4] = '{13'h0A80, 4'd2, 8'h0A, 16'h0100, 4, 20};

      rst = 1'b1; cmd_valid = 1'b0; cmd_word = 13'd0;
      go = 1'b0; abort = 1'b0; sw_rdy = 1'b1;
      repeat (2) step();
      chk_reset_outputs("por");
      rst = 1'b0;
      step();

      // go with an empty FIFO: single done pulse, never busy
      pulse_go();
      chk("empty_go_done", done, 1'b1);
      chk("empty_go_busy", busy, 1'b0);
      step();
      chk("empty_go_done_clr", done, 1'b0);

      // table of single commands
      for (int v = 0; v < 5; v++) begin
         base = cs_cnt;
         push_cmd(vecs[v].word);
         chk($sformatf("v%0d_level1", v), level, 4'd1);
         pulse_go();
         chk($sformatf("v%0d_busy", v), busy,    1'b1);
         chk($sformatf("v%0d_cs", v),   sw_cs,   1'b1);
         chk($sformatf("v%0d_op", v),   sw_op,   vecs[v].op);
         chk($sformatf("v%0d_addr", v), sw_addr, vecs[v].addr);
         chk($sformatf("v%0d_data", v), sw_data, vecs[v].data);
         finish_cmd(vecs[v].lo_d, vecs[v].hi_d);
         count_done(4, cnt);
         chk($sformatf("v%0d_done_cnt", v),  cnt,           1);
         chk($sformatf("v%0d_busy_end", v),  busy,          1'b0);
         chk($sformatf("v%0d_op_idle", v),   sw_op,         4'd0);
         chk($sformatf("v%0d_addr_hold", v), sw_addr,       vecs[v].addr);
         chk($sformatf("v%0d_data_hold", v), sw_data,       vecs[v].data);
         chk($sformatf("v%0d_cs_cnt", v),    cs_cnt - base, 1);
      end

      // fill to 8, refused 9th, ordered drain
      base = cs_cnt;
      for (int i = 0; i < 8; i++) begin
         w = {1'b0, 4'(i + 8), i[0], 3'(i), 4'(15 - i)};
         push_cmd(w);
      end
      chk("full_level", level, 4'd8);
      chk("full_ready", cmd_ready, 1'b0);
      push_cmd(13'h1FFF);
      chk("full_9th_level", level, 4'd8);
      pulse_go();
      for (int i = 0; i < 8; i++) begin
         wait_cs(30, ok);
         chk($sformatf("drain%0d_seen", i), ok, 1'b1);
         exp_data = {7'd0, i[0], 1'b0, 3'(i), 4'(15 - i)};
         chk($sformatf("drain%0d_op", i),   sw_op,   4'd2);
         chk($sformatf("drain%0d_addr", i), sw_addr, 8'(i + 8));
         chk($sformatf("drain%0d_data", i), sw_data, exp_data);
         finish_cmd(1, 3 + i);
         chk($sformatf("drain%0d_no_early_cs", i), cs_cnt - base, i + 1);
      end
      count_done(4, cnt);
      chk("drain_done_cnt", cnt, 1);
      chk("drain_level", level, 4'd0);
      chk("drain_busy", busy, 1'b0);
      chk("drain_cs_total", cs_cnt - base, 8);

      // push coincident with the ISSUE pop at level 4
      base = cs_cnt;
      for (int i = 0; i < 4; i++) push_cmd(13'h1100 + 13'(i << 8));
      chk("pp_level4", level, 4'd4);
      pulse_go();
      chk("pp_cs", sw_cs, 1'b1);
      cmd_valid = 1'b1;
      cmd_word  = 13'h0612;
      step();
      cmd_valid = 1'b0;
      chk("pp_level_same", level, 4'd4);
      step();
      sw_rdy = 1'b0;
      repeat (2) step();
      sw_rdy = 1'b1;
      for (int i = 0; i < 4; i++) begin
         wait_cs(30, ok);
         chk($sformatf("pp_rest%0d_seen", i), ok, 1'b1);
         finish_cmd(2, 2);
      end
      count_done(4, cnt);
      chk("pp_done_cnt", cnt, 1);
      chk("pp_cs_total", cs_cnt - base, 5);
      chk("pp_last_addr", sw_addr, 8'h06);

      // sw_rdy stuck high -> timeout
      base = cs_cnt;
      push_cmd(13'h0211);
      push_cmd(13'h0322);
      pulse_go();
      chk("tmo_cs", sw_cs, 1'b1);
      cyc = 0;
      for (int k = 1; k <= 150; k++) begin
         step();
         if (err === 1'b1) begin
            cyc = k;
            break;
         end
      end
      chk("tmo_err_set", err, 1'b1);
      chk("tmo_window", (cyc >= 100 && cyc <= 103), 1'b1);
      chk("tmo_busy", busy, 1'b1);
      chk("tmo_cs_low", sw_cs, 1'b0);
      chk("tmo_level", level, 4'd0);
      push_cmd(13'h0433);
      repeat (3) step();
      chk("tmo_no_push", level, 4'd0);
      chk("tmo_err_sticky", err, 1'b1);
      chk("tmo_cs_cnt", cs_cnt - base, 1);
      abort = 1'b1;
      go    = 1'b1;
      step();
      abort = 1'b0;
      go    = 1'b0;
      chk("abort_err_clr", err, 1'b0);
      chk("abort_busy", busy, 1'b0);
      step();
      chk("abort_go_ignored", busy, 1'b0);
      chk("abort_go_no_done", done, 1'b0);

      // abort mid-drain with a push in the same cycle
      base = cs_cnt;
      for (int i = 0; i < 3; i++) push_cmd(13'h0700 + 13'(i));
      pulse_go();
      step();
      abort     = 1'b1;
      cmd_valid = 1'b1;
      cmd_word  = 13'h0855;
      step();
      abort     = 1'b0;
      cmd_valid = 1'b0;
      chk("amid_level", level, 4'd0);
      chk("amid_busy", busy, 1'b0);
      sw_rdy = 1'b0;
      repeat (3) step();
      sw_rdy = 1'b1;
      repeat (5) step();
      chk("amid_cs_cnt", cs_cnt - base, 1);

      // asynchronous reset while in WAIT_HI with 3 queued
      base = cs_cnt;
      for (int i = 0; i < 4; i++) push_cmd(13'h0900 + 13'(i << 8) + 13'h0011);
      pulse_go();
      chk("rst_cs", sw_cs, 1'b1);
      step();
      sw_rdy = 1'b0;
      step();
      step();
      chk("rst_pre_level", level, 4'd3);
      chk("rst_pre_busy", busy, 1'b1);
      chk("rst_pre_addr", sw_addr, 8'h09);
      #2;
      rst = 1'b1;
      #1;
      chk_reset_outputs("async");
      repeat (2) step();
      rst = 1'b0;
      sw_rdy = 1'b1;
      repeat (20) step();
      chk("rst_no_cs", cs_cnt - base, 1);
      chk("rst_level", level, 4'd0);
      chk("rst_busy", busy, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/switch_sequencer.md
SWITCH_SEQUENCER -- requirements
Module: switch_sequencer

Interface
REQ-001 SHALL have port clk  in  1  single system clock; all state changes on its rising edge.
REQ-002 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-003 SHALL have port cmd_valid  in  1  host offers one command this cycle.
REQ-004 SHALL have port cmd_word  in  13  [12]=type (1 switch reset, 0 crosspoint write), [11:8]=switch no, [7]=data bit, [6:4]=Y, [3:0]=X.
REQ-005 SHALL have port cmd_ready  out  1  FIFO not full; a push occurs when cmd_valid and cmd_ready are both high.
REQ-006 SHALL have port go  in  1  one-cycle pulse that starts draining the FIFO.
REQ-007 SHALL have port abort  in  1  one-cycle pulse that flushes the FIFO and returns to IDLE.
REQ-008 SHALL have ports sw_cs, sw_op[3:0], sw_addr[7:0], sw_data[15:0]  out  the command port of the downstream switch interface.
REQ-009 SHALL have port sw_rdy  in  1  downstream ready.
REQ-010 SHALL have ports busy (1), done (1, pulse), err (1, sticky) and level (4, FIFO occupancy 0..8)  out.

Function
REQ-011 SHALL hold an 8-entry x 13-bit FIFO with 3-bit wrapping read and write pointers and a 4-bit level count.
REQ-012 SHALL drive cmd_ready = (level != 8); a push while full is impossible by construction.
REQ-013 On a simultaneous push and pop in one cycle, SHALL write and read both entries and leave level unchanged.
REQ-014 SHALL use FSM states IDLE, ISSUE, WAIT_LO, WAIT_HI, ERROR.
REQ-015 IDLE: on go with level>0, SHALL go to ISSUE and assert busy; on go with level=0, SHALL pulse done for 1 cycle and stay in IDLE.
REQ-016 ISSUE: SHALL pop the head entry and drive sw_cs=1 for exactly 1 cycle.
REQ-017 ISSUE: sw_op SHALL be 4'b0001 for type 1 and 4'b0010 for type 0.
REQ-018 ISSUE: sw_addr SHALL be {4'b0, switch no}.
REQ-019 ISSUE: sw_data SHALL be {7'b0, data, 1'b0, Y, X}.
REQ-020 ISSUE: SHALL go to WAIT_LO on the next cycle.
REQ-021 WAIT_LO: SHALL wait for sw_rdy=0, then go to WAIT_HI.
REQ-022 WAIT_HI: SHALL wait for sw_rdy=1.
REQ-023 WAIT_HI: on sw_rdy=1 with level>0, SHALL go to ISSUE; with level=0, SHALL go to IDLE, pulse done for 1 cycle and deassert busy.
REQ-024 SHALL run a 7-bit timeout counter that clears on entry to WAIT_LO and on entry to WAIT_HI.
REQ-025 If the timeout counter reaches 100 in WAIT_LO or WAIT_HI, SHALL set err, flush the FIFO and go to ERROR.
REQ-026 ERROR: SHALL hold busy=1 and sw_cs=0 until abort.
REQ-027 abort, in any state, SHALL clear the FIFO, clear err and go to IDLE on the next edge; abort has priority over go and push in the same cycle.
REQ-028 Pushes SHALL be accepted in every state except ERROR, so the host can refill the FIFO during a drain.
REQ-029 When sw_cs=0, sw_op SHALL be 0; sw_addr and sw_data SHALL hold their last values.
REQ-030 go received while busy SHALL be ignored.

Reset
REQ-031 While rst=1, outputs SHALL be immediately: sw_cs=0, sw_op=0, sw_addr=0, sw_data=0, busy=0, done=0, err=0, level=0, cmd_ready=1.
REQ-032 While rst=1, the FSM SHALL be in IDLE with both FIFO pointers at 0.
REQ-033 Reset asserted mid-operation SHALL discard the queued commands and any in-flight command without issuing a further sw_cs.

Verification
REQ-034 Push 1 write (sw 3, X=5, Y=2, data=1), pulse go, model sw_rdy low 2 cycles after cs and high 10 cycles later -> one sw_cs pulse with op=2, addr=0x03, data=0x0125; done pulses once; busy falls.
REQ-035 Push 8 commands -> cmd_ready=0 and level=8; a 9th cmd_valid is not accepted; go -> 8 sequential cs pulses with no pulse issued before the preceding rdy rise.
REQ-036 Push a type-1 command for sw 5 -> op=1, addr=0x05.
REQ-037 Keep sw_rdy stuck high after cs -> err=1 after 100 cycles, state ERROR, level=0; abort -> err=0, IDLE.
REQ-038 Push on the same cycle as the pop in ISSUE at level=4 -> level stays 4.
REQ-039 Assert rst during WAIT_HI with 3 entries queued -> outputs reset asynchronously; no sw_cs afterwards; level=0.
